// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter shared definitions
// FSM encodings, CU opcodes, arbitration helper
package mem_arbiter_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CPU_ACC  = 3'd1;
  localparam logic [2:0] S_CPU_DONE = 3'd2;
  localparam logic [2:0] S_LDR_ACC  = 3'd3;
  localparam logic [2:0] S_LDR_DONE = 3'd4;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  // Round-robin: loader wins a tie unless it had the last grant
  function automatic logic pick_ldr(
    input logic cpu_req,
    input logic ldr_req,
    input logic last_ldr
  );
    return ldr_req & (~cpu_req | ~last_ldr);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle
// CPU, loader and memory sides in one interface
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic [DW-1:0] ldr_rdata;
  logic          ldr_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          err_timeout;

  modport master (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  mem_rdata, mem_ready,
    output cpu_rdata, cpu_stall,
    output ldr_rdata, ldr_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output err_timeout
  );

  modport slave (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output mem_rdata, mem_ready,
    input  cpu_rdata, cpu_stall,
    input  ldr_rdata, ldr_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  err_timeout
  );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Access timeout counter
// o_tc flags the cycle whose increment reaches TIMEOUT
module mem_timeout_cnt #(
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [3:0] r_cnt;

  // Clear has priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= 4'd0;
    else if (i_clr)
      r_cnt <= 4'd0;
    else if (i_en)
      r_cnt <= r_cnt + 4'd1;
  end

  assign o_tc = i_en & (r_cnt == TIMEOUT - 4'd1);
endmodule

// File: rtl/mem_arbiter.sv
// Unified memory arbiter: CPU vs loader
// Round-robin grant, req/ready sequencing, timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int         AW      = 32,
  parameter int         DW      = 32,
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);
  logic [2:0]    r_state;
  logic          r_last_ldr;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_ldr_rdata;
  logic          r_err;

  logic w_cpu_req;
  logic w_grant_ldr;
  logic w_grant_cpu;
  logic w_acc;
  logic w_is_cpu;
  logic w_cnt_en;
  logic w_tc;

  assign w_cpu_req   = bus.cpu_rd | bus.cpu_wr;
  assign w_grant_ldr = pick_ldr(w_cpu_req,
                                bus.ldr_req,
                                r_last_ldr);
  assign w_grant_cpu = w_cpu_req & ~w_grant_ldr;
  assign w_is_cpu    = (r_state == S_CPU_ACC);
  assign w_acc       = w_is_cpu |
                       (r_state == S_LDR_ACC);
  assign w_cnt_en    = w_acc & ~bus.mem_ready;

  mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state == S_IDLE),
    .i_en  (w_cnt_en),
    .o_tc  (w_tc)
  );

  // Grant, access sequencing and data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last_ldr  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_ldr) begin
            r_state     <= S_LDR_ACC;
            r_last_ldr  <= 1'b1;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.ldr_we;
            r_mem_addr  <= bus.ldr_addr;
            r_mem_wdata <= bus.ldr_wdata;
          end else if (w_grant_cpu) begin
            r_state     <= S_CPU_ACC;
            r_last_ldr  <= 1'b0;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.cpu_wr;
            r_mem_addr  <= bus.cpu_addr;
            r_mem_wdata <= bus.cpu_wdata;
          end
        end
        S_CPU_ACC, S_LDR_ACC: begin
          if (bus.mem_ready || w_tc) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= w_is_cpu ? S_CPU_DONE
                                 : S_LDR_DONE;
            if (!bus.mem_ready)
              r_err <= 1'b1;
            if (!r_mem_we) begin
              if (w_is_cpu)
                r_cpu_rdata <= bus.mem_ready ?
                               bus.mem_rdata : '0;
              else
                r_ldr_rdata <= bus.mem_ready ?
                               bus.mem_rdata : '0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.cpu_rdata   = r_cpu_rdata;
  assign bus.ldr_rdata   = r_ldr_rdata;
  assign bus.err_timeout = r_err;
  assign bus.ldr_done    = (r_state == S_LDR_DONE);
  assign bus.cpu_stall   = w_cpu_req &
                           (r_state != S_CPU_DONE);
endmodule

// File: tb/tb_mem_arbiter.sv
// mem_arbiter scoreboard bench
// Directed vectors, queue-based monitor
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus();

  mem_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(4'd15)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } mem_exp_t;

  typedef struct {
    logic [31:0] rdata;
    int          stalls;
    logic        err;
  } cpu_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } ldr_exp_t;

  mem_exp_t exp_mem[$];
  cpu_exp_t exp_cpu[$];
  ldr_exp_t exp_ldr[$];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] img [16];
  int ready_wait = 0;
  int wcnt = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Memory model: ready after ready_wait low cycles
  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (wcnt == ready_wait) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = img[bus.mem_addr[5:2]];
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
      end
      wcnt++;
    end else begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      wcnt = 0;
    end
  end

  mem_exp_t cur;
  bit in_acc = 1'b0;
  bit stray = 1'b0;
  int en_cnt = 0;
  int stall_cnt = 0;

  // Monitor: pops expectations on DUT events
  always @(negedge clk) begin
    if (!rst_n) begin
      in_acc = 1'b0;
      stray = 1'b0;
      en_cnt = 0;
      stall_cnt = 0;
    end else begin
      if (bus.mem_en) begin
        if (!in_acc) begin
          in_acc = 1'b1;
          en_cnt = 0;
          if (exp_mem.size() == 0) begin
            stray = 1'b1;
            vectors++;
            miscompares++;
            $display("FAIL mem_issue: stray access addr %h",
                     bus.mem_addr);
          end else begin
            cur = exp_mem.pop_front();
          end
        end
        if (!stray) begin
          chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
          chk("mem_addr", bus.mem_addr, cur.addr);
          chk("mem_wdata", bus.mem_wdata, cur.wdata);
        end
        en_cnt++;
      end else if (in_acc) begin
        in_acc = 1'b0;
        if (!stray && cur.len > 0)
          chk("mem_en_len", en_cnt, cur.len);
        stray = 1'b0;
      end

      if (bus.cpu_rd | bus.cpu_wr) begin
        if (bus.cpu_stall) begin
          stall_cnt++;
        end else if (exp_cpu.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL cpu_done: unexpected release");
        end else begin
          cpu_exp_t e;
          e = exp_cpu.pop_front();
          chk("cpu_stalls", stall_cnt, e.stalls);
          chk("cpu_rdata", bus.cpu_rdata, e.rdata);
          chk("cpu_err", 32'(bus.err_timeout),
              32'(e.err));
          stall_cnt = 0;
        end
      end else begin
        chk("cpu_stall_idle", 32'(bus.cpu_stall), 0);
      end

      if (bus.ldr_done) begin
        if (exp_ldr.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL ldr_done: unexpected pulse");
        end else begin
          ldr_exp_t l;
          l = exp_ldr.pop_front();
          chk("ldr_rdata", bus.ldr_rdata, l.rdata);
          chk("ldr_err", 32'(bus.err_timeout),
              32'(l.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cpu_done();
    bit got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (!bus.cpu_stall) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL cpu_wait: got stall expected release");
    end
    tick();
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
  endtask

  task automatic wait_ldr_done();
    bit got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus.ldr_done) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ldr_wait: got no done expected pulse");
    end
    tick();
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_mem_en"}, 32'(bus.mem_en), 0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
    chk({tag, "_ldr_rdata"}, bus.ldr_rdata, 0);
    chk({tag, "_ldr_done"}, 32'(bus.ldr_done), 0);
    chk({tag, "_err"}, 32'(bus.err_timeout), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_rd = 1'b0;
    bus.cpu_wr = 1'b0;
    bus.cpu_addr = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.ldr_req = 1'b0;
    bus.ldr_we = 1'b0;
    bus.ldr_addr = 32'h0;
    bus.ldr_wdata = 32'h0;
    for (int i = 0; i < 16; i++) img[i] = 32'h0;
    img[1]  = 32'h2009_0005;
    img[2]  = 32'h1111_0008;
    img[8]  = 32'hCAFE_0020;
    img[12] = 32'h5555_0030;
    img[15] = 32'h0F0F_F0F0;

    repeat (2) @(posedge clk);
    #1;
    chk_zero_outs("rst");
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a CPU access
    ready_wait = 255;
    exp_mem.push_back('{1'b0, 32'h40, 32'h0, 0});
    bus.cpu_addr = 32'h40;
    bus.cpu_rd = 1'b1;
    repeat (3) tick();
    chk("t1_mem_en", 32'(bus.mem_en), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outs("t1");
    chk("t1_stall_held", 32'(bus.cpu_stall), 1);
    @(negedge clk);
    #1;
    bus.cpu_rd = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t1_idle_no_en", 32'(bus.mem_en), 0);

    // CPU read, zero wait
    ready_wait = 0;
    exp_mem.push_back('{1'b0, 32'h4, 32'h0, 1});
    exp_cpu.push_back('{32'h2009_0005, 2, 1'b0});
    bus.cpu_addr = 32'h4;
    bus.cpu_rd = 1'b1;
    wait_cpu_done();

    // CPU write, three wait states
    ready_wait = 3;
    exp_mem.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF, 4});
    exp_cpu.push_back('{32'h2009_0005, 5, 1'b0});
    bus.cpu_addr = 32'h10;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    bus.cpu_wr = 1'b1;
    wait_cpu_done();
    bus.cpu_wdata = 32'h0;

    // Simultaneous requests: loader, CPU, loader
    ready_wait = 0;
    exp_mem.push_back('{1'b1, 32'h0, 32'h1234_5678, 1});
    exp_mem.push_back('{1'b0, 32'h20, 32'h0, 1});
    exp_mem.push_back('{1'b0, 32'h8, 32'h0, 1});
    exp_cpu.push_back('{32'hCAFE_0020, 5, 1'b0});
    exp_ldr.push_back('{32'h0, 1'b0});
    exp_ldr.push_back('{32'h1111_0008, 1'b0});
    bus.ldr_we = 1'b1;
    bus.ldr_addr = 32'h0;
    bus.ldr_wdata = 32'h1234_5678;
    bus.ldr_req = 1'b1;
    bus.cpu_addr = 32'h20;
    bus.cpu_rd = 1'b1;
    fork
      wait_cpu_done();
      begin
        wait_ldr_done();
        bus.ldr_we = 1'b0;
        bus.ldr_addr = 32'h8;
        bus.ldr_wdata = 32'h0;
        wait_ldr_done();
        bus.ldr_req = 1'b0;
      end
    join
    tick();

    // mem_ready on the last allowed cycle
    ready_wait = 14;
    exp_mem.push_back('{1'b0, 32'h3C, 32'h0, 15});
    exp_cpu.push_back('{32'h0F0F_F0F0, 16, 1'b0});
    bus.cpu_addr = 32'h3C;
    bus.cpu_rd = 1'b1;
    wait_cpu_done();

    // No mem_ready at all: timeout
    ready_wait = 255;
    exp_mem.push_back('{1'b0, 32'h30, 32'h0, 15});
    exp_cpu.push_back('{32'h0, 16, 1'b1});
    bus.cpu_addr = 32'h30;
    bus.cpu_rd = 1'b1;
    wait_cpu_done();
    repeat (5) tick();
    chk("t5_err_sticky", 32'(bus.err_timeout), 1);
    chk("t5_no_en", 32'(bus.mem_en), 0);

    rst_n = 1'b0;
    #1;
    chk("t5_err_rst", 32'(bus.err_timeout), 0);
    tick();
    rst_n = 1'b1;
    tick();

    chk("q_mem_empty", exp_mem.size(), 0);
    chk("q_cpu_empty", exp_cpu.size(), 0);
    chk("q_ldr_empty", exp_ldr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the multicycle control unit/datapath and the single unified instruction/data memory.
- Shares that memory between two requesters: the CPU (driven by MemRd/MemWr/IorD-selected address) and a program loader/debug port.
- Sequences variable-latency memory accesses using a req/ready handshake, with a timeout.
- Raises cpu_stall. The control unit must hold its state, and suppress PCWr/IRWr/RegWr, while cpu_stall is high.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 15, max cycles waiting for mem_ready before forced completion (4-bit counter; legal values 1..15)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
cpu_rd  in  1  CPU read request (MemRd)
cpu_wr  in  1  CPU write request (MemWr)
cpu_addr  in  AW  CPU address (PC or ALUOut, after IorD mux)
cpu_wdata  in  DW  CPU store data (register B)
cpu_rdata  out  DW  registered read data for IR/MDR
cpu_stall  out  1  CPU must hold state this cycle
ldr_req  in  1  loader request, held until ldr_done
ldr_we  in  1  loader write (1) / read (0)
ldr_addr  in  AW  loader address
ldr_wdata  in  DW  loader write data
ldr_rdata  out  DW  registered loader read data
ldr_done  out  1  one-cycle pulse: loader access complete
mem_en  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  memory completion
err_timeout  out  1  sticky flag; cleared only by reset

Behaviour:
Reset (rst_n low, asynchronous):
- State = IDLE.
- All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, ldr_rdata, ldr_done, err_timeout.
- last_ldr = 0.
- A reset mid-access abandons the access; no completion pulse is generated.

States: IDLE, CPU_ACC, CPU_DONE, LDR_ACC, LDR_DONE.

Arbitration (in IDLE):
- A CPU request (cpu_rd|cpu_wr) and ldr_req may both be pending. The winner is the loader if last_ldr == 0, otherwise the CPU. This is round-robin.
- With a single requester, that requester wins.
- last_ldr is set when the loader is granted and cleared when the CPU is granted.
- cpu_rd and cpu_wr both high: treat as a write.

Issue:
- On grant, mem_en/mem_we/mem_addr/mem_wdata are registered and asserted from the next cycle. Minimum access latency is request seen at cycle N, mem_en at N+1.
- Request fields are latched at grant and held constant until completion.
- The timeout counter is cleared to 0.

CPU_ACC / LDR_ACC:
- mem_en stays high; the counter increments each cycle mem_ready is low.
- On mem_ready:
  - capture mem_rdata into cpu_rdata or ldr_rdata (reads only; writes leave it unchanged);
  - drop mem_en/mem_we at the same edge;
  - go to the corresponding DONE state.
- If the counter reaches TIMEOUT with mem_ready still low:
  - set err_timeout;
  - load rdata with 0 (reads only);
  - drop mem_en;
  - go to the DONE state.
- If mem_ready and the timeout occur in the same cycle, mem_ready wins and err_timeout is not set.

CPU_DONE:
- cpu_stall = 0, so the CU advances at the end of this cycle.
- No new access starts for the still-asserted request.
- Next state is IDLE.

LDR_DONE:
- ldr_done = 1 for exactly this cycle.
- Next state is IDLE.
- The loader must drop ldr_req or present a new request.

cpu_stall (combinational):
- cpu_stall = (cpu_rd|cpu_wr) & (state != CPU_DONE).
- It is therefore high through IDLE, loader service and CPU_ACC.
- It is 0 when the CPU has no request.

Fixed CPU latency with zero-wait memory (mem_ready in the first mem_en cycle):
- IDLE → CPU_ACC → CPU_DONE: the CU sees 2 stall cycles per access.

mem_ready outside an access (mem_en low) is ignored.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=0, CPU_ACC=1, CPU_DONE=2, LDR_ACC=3, LDR_DONE=4, 3 bits;
  - the CU opcode constants (R=000000, lw=100011, sw=101011, beq=000100, j=000010, addiu=001001), so the CU and bench share them.
- One natural sub-module: mem_timeout_cnt (4-bit clear/enable counter with a terminal-count output).

Test Plan:
1. Reset mid-access: mem_en=1 in CPU_ACC, pulse rst_n low → all outputs 0 asynchronously; state IDLE; no ldr_done or stall release observed.
2. CPU read, zero-wait: cpu_rd=1, addr=0x0000_0004, mem_rdata=0x2009_0005 with ready in the first mem_en cycle → mem_en for 1 cycle; cpu_stall high for 2 cycles; cpu_rdata=0x2009_0005 in CPU_DONE.
3. CPU write, 3-wait: cpu_wr=1, addr=0x10, wdata=0xDEAD_BEEF, mem_ready after 3 low cycles → mem_we=1 and addr/data stable for 4 cycles; cpu_rdata unchanged; stall released after completion.
4. Simultaneous requests: ldr_req (write 0x0/0x1234_5678) and cpu_rd together from reset → loader served first with ldr_done pulse; then CPU; on the next simultaneous pair the CPU wins.
5. Timeout: cpu_rd with mem_ready never asserted → after 15 cycles err_timeout=1 (sticky), cpu_rdata=0, stall released; err_timeout stays 1 until rst_n.
6. ready/timeout tie: mem_ready arrives exactly on the 15th cycle → data captured and err_timeout stays 0.
